// File: rtl/cmos_vid_pkg.sv
// rtl/cmos_vid_pkg.sv - shared types and FIFO entry layout for the video capture stage
package cmos_vid_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VBLANK = 2'd1,
    ST_FRAME  = 2'd2
  } vid_state_e;

  localparam int ENTRY_W  = 26;
  localparam int USER_BIT = 25;
  localparam int LAST_BIT = 24;

endpackage

// File: rtl/vid_fifo_sync.sv
// rtl/vid_fifo_sync.sv - single-clock first-word-fall-through FIFO
module vid_fifo_sync #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 26
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             wr_ok, rd_ok;

  // Extra MSB on each pointer separates the full case from the empty case.
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign wr_ok     = wr_en_i && !full_o;
  assign rd_ok     = rd_en_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_ok};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_ok};
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/cmos_vid2axis.sv
// rtl/cmos_vid2axis.sv - sensor hs/vs/RGB capture to frame-aligned AXI4-Stream video
// Optional frame statistics counters: CMOS_VID2AXIS_STATS_EN
module cmos_vid2axis
  import cmos_vid_pkg::*;
#(
  parameter int FIFO_DEPTH = 1024,
  parameter int CNT_W      = 12
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             vid_clk_ce,
  input  logic             hs_i,
  input  logic             vs_i,
  input  logic [23:0]      rgb_i,
  output logic [23:0]      m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tuser,
  output logic             m_axis_tlast,
  output logic             overflow_o,
  output logic [CNT_W-1:0] frame_w_o,
  output logic [CNT_W-1:0] frame_h_o,
  output logic [15:0]      frame_cnt_o
);
  vid_state_e         state_q, state_d;
  logic               hs_q, hs_d, vs_q, vs_d, sof_q, sof_d, ovf_q, ovf_d;
  logic               hold_vld_q, hold_vld_d, hold_user_q, hold_user_d;
  logic [23:0]        hold_data_q, hold_data_d;
  logic               push, push_last, fifo_full, fifo_empty;
  logic               vs_rise, hs_fall;
  logic [ENTRY_W-1:0] fifo_din, fifo_dout;

  assign vs_rise = vid_clk_ce && vs_i && !vs_q;
  assign hs_fall = vid_clk_ce && hs_q && !hs_i;

  always_comb begin
    state_d     = state_q;
    hs_d        = hs_q;
    vs_d        = vs_q;
    sof_d       = sof_q;
    ovf_d       = ovf_q;
    hold_vld_d  = hold_vld_q;
    hold_user_d = hold_user_q;
    hold_data_d = hold_data_q;
    push        = 1'b0;
    push_last   = 1'b0;
    if (vid_clk_ce) begin
      hs_d = hs_i;
      vs_d = vs_i;
      case (state_q)
        ST_IDLE:   if (vs_i) state_d = ST_VBLANK;
        ST_VBLANK: if (!vs_i) begin
          state_d = ST_FRAME;
          sof_d   = 1'b1;
        end
        ST_FRAME: begin
          // vsync closes the frame; a coincident hs fall folds into this one push.
          if (vs_rise) begin
            push       = hold_vld_q;
            push_last  = 1'b1;
            hold_vld_d = 1'b0;
            state_d    = ST_VBLANK;
          end else if (hs_i) begin
            push        = hold_vld_q;
            hold_vld_d  = 1'b1;
            hold_user_d = sof_q;
            hold_data_d = rgb_i;
            sof_d       = 1'b0;
          end else if (hs_fall) begin
            push       = hold_vld_q;
            push_last  = 1'b1;
            hold_vld_d = 1'b0;
          end
          if (push && fifo_full) begin
            ovf_d      = 1'b1;
            hold_vld_d = 1'b0;
            state_d    = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      sof_q       <= 1'b0;
      ovf_q       <= 1'b0;
      hold_vld_q  <= 1'b0;
      hold_user_q <= 1'b0;
      hold_data_q <= '0;
    end else begin
      state_q     <= state_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      sof_q       <= sof_d;
      ovf_q       <= ovf_d;
      hold_vld_q  <= hold_vld_d;
      hold_user_q <= hold_user_d;
      hold_data_q <= hold_data_d;
    end
  end

  always_comb begin
    fifo_din           = '0;
    fifo_din[USER_BIT] = hold_user_q;
    fifo_din[LAST_BIT] = push_last;
    fifo_din[23:0]     = hold_data_q;
  end

  vid_fifo_sync #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .wr_en_i   (push),
    .wr_data_i (fifo_din),
    .rd_en_i   (m_axis_tready),
    .rd_data_o (fifo_dout),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Masked with empty so the bus reads zero instead of stale RAM contents.
  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_empty ? 24'd0 : fifo_dout[23:0];
  assign m_axis_tuser  = !fifo_empty && fifo_dout[USER_BIT];
  assign m_axis_tlast  = !fifo_empty && fifo_dout[LAST_BIT];
  assign overflow_o    = ovf_q;

`ifdef CMOS_VID2AXIS_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [CNT_W-1:0] pix_q, pix_d, line_w_q, line_w_d, lines_q, lines_d;
  logic [CNT_W-1:0] fw_q, fw_d, fh_q, fh_d, lines_inc;
  logic [15:0]      fcnt_q, fcnt_d;
  logic             frame_start, pix_evt, line_evt, frame_done;

  assign frame_start = vid_clk_ce && (state_q == ST_VBLANK) && !vs_i;
  assign pix_evt     = vid_clk_ce && (state_q == ST_FRAME) && hs_i && !vs_rise;
  assign line_evt    = (state_q == ST_FRAME) && hs_fall;
  assign frame_done  = (state_q == ST_FRAME) && vs_rise && !(push && fifo_full);
  assign lines_inc   = (lines_q == '1) ? lines_q : lines_q + CNT_ONE;

  always_comb begin
    pix_d    = pix_q;
    line_w_d = line_w_q;
    lines_d  = lines_q;
    fw_d     = fw_q;
    fh_d     = fh_q;
    fcnt_d   = fcnt_q;
    if (frame_start) begin
      pix_d    = '0;
      line_w_d = '0;
      lines_d  = '0;
    end else begin
      if (pix_evt && pix_q != '1) pix_d = pix_q + CNT_ONE;
      if (line_evt) begin
        line_w_d = pix_q;
        pix_d    = '0;
        lines_d  = lines_inc;
      end
      if (frame_done) begin
        fw_d   = line_evt ? pix_q : line_w_q;
        fh_d   = line_evt ? lines_inc : lines_q;
        fcnt_d = fcnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pix_q    <= '0;
      line_w_q <= '0;
      lines_q  <= '0;
      fw_q     <= '0;
      fh_q     <= '0;
      fcnt_q   <= '0;
    end else begin
      pix_q    <= pix_d;
      line_w_q <= line_w_d;
      lines_q  <= lines_d;
      fw_q     <= fw_d;
      fh_q     <= fh_d;
      fcnt_q   <= fcnt_d;
    end
  end

  assign frame_w_o   = fw_q;
  assign frame_h_o   = fh_q;
  assign frame_cnt_o = fcnt_q;
`else
  assign frame_w_o   = '0;
  assign frame_h_o   = '0;
  assign frame_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cmos_vid2axis.sv
// tb/tb_cmos_vid2axis.sv - randomized directed bench for cmos_vid2axis with a frame-level beat model
module tb_cmos_vid2axis;
  logic        clk = 1'b0;
  logic        rst_n, ce, hs, vs, tready;
  logic [23:0] rgb;
  logic [23:0] tdata;
  logic        tvalid, tuser, tlast, ovf;
  logic [11:0] fw, fh;
  logic [15:0] fc;

  int          checks = 0, errors = 0;
  int          cyc = 0, beats = 0, ready_mode = 0, ce_gap = 1;
  logic [25:0] exp_q[$];
  logic [25:0] prev_beat;
  logic        prev_stall = 1'b0;
  bit          pend_valid = 0;
  int          pend_w = 0, pend_h = 0, exp_fw = 0, exp_fh = 0, exp_fc = 0;

  cmos_vid2axis #(.FIFO_DEPTH(16), .CNT_W(12)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .vid_clk_ce(ce), .hs_i(hs), .vs_i(vs), .rgb_i(rgb),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .m_axis_tuser(tuser), .m_axis_tlast(tlast), .overflow_o(ovf),
    .frame_w_o(fw), .frame_h_o(fh), .frame_cnt_o(fc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // One clock: drive inputs at negedge, then judge the beat that the next posedge will transfer.
  task automatic clk_cycle(input logic c, input logic h, input logic v, input logic [23:0] d);
    logic [25:0] got, want;
    @(negedge clk);
    ce = c; hs = h; vs = v; rgb = d;
    case (ready_mode)
      0:       tready = 1'b1;
      1:       tready = (cyc % 3 == 0);
      2:       tready = ($urandom % 4 != 0);
      default: tready = 1'b0;
    endcase
    cyc++;
    got = {tuser, tlast, tdata};
    if (prev_stall) begin
      checks++;
      assert (tvalid === 1'b1 && got === prev_beat) else begin
        errors++;
        $error("FAIL stall_hold got=%h want=%h", got, prev_beat);
      end
    end
    if (tvalid === 1'b1 && tready) begin
      want = 'x;
      if (exp_q.size() > 0) want = exp_q.pop_front();
      beats++;
      checks++;
      assert (got === want) else begin
        errors++;
        $error("FAIL beat%0d got=%h want=%h", beats, got, want);
      end
    end
    prev_stall = (tvalid === 1'b1) && !tready;
    prev_beat  = got;
  endtask

  // ce-low cycles carry random garbage on every video input; only the ce cycle matters.
  task automatic ce_cycle(input logic h, input logic v, input logic [23:0] d);
    repeat (ce_gap) clk_cycle(1'b0, 1'($urandom), 1'($urandom), 24'($urandom));
    clk_cycle(1'b1, h, v, d);
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, "_w"}, 32'(fw), exp_fw);
    chk({tag, "_h"}, 32'(fh), exp_fh);
    chk({tag, "_cnt"}, 32'(fc), exp_fc);
  endtask

  // vsync pulse (with a stray hs pulse inside it), back porch, then w x h pixels.
  task automatic send_frame(input int w, input int h, input bit tight, input int keep, input bit ramp);
    int n = 0;
    logic [23:0] d;
    ce_cycle(1'b0, 1'b1, 24'($urandom));
`ifdef CMOS_VID2AXIS_STATS_EN
    if (pend_valid) begin
      exp_fw = pend_w;
      exp_fh = pend_h;
      exp_fc = (exp_fc + 1) & 16'hffff;
    end
`endif
    pend_valid = 0;
    ce_cycle(1'b1, 1'b1, 24'($urandom));
    chk_stats("stats_at_vs");
    ce_cycle(1'b0, 1'b1, 24'($urandom));
    repeat (2) ce_cycle(1'b0, 1'b0, 24'($urandom));
    for (int l = 0; l < h; l++) begin
      for (int p = 0; p < w; p++) begin
        d = ramp ? 24'(n + 1) : 24'($urandom);
        if (keep < 0 || n < keep) exp_q.push_back({(l == 0 && p == 0), (p == w - 1), d});
        n++;
        ce_cycle(1'b1, 1'b0, d);
      end
      if (!(tight && l == h - 1)) repeat (2) ce_cycle(1'b0, 1'b0, 24'($urandom));
    end
    pend_valid = (keep < 0);
    pend_w = w;
    pend_h = h;
  endtask

  task automatic drain(input string tag);
    ready_mode = 0;
    repeat (2) ce_cycle(1'b0, 1'b0, 24'd0);
    for (int i = 0; i < 400 && exp_q.size() > 0; i++) clk_cycle(1'b0, 1'b0, 1'b0, 24'd0);
    repeat (3) clk_cycle(1'b0, 1'b0, 1'b0, 24'd0);
    chk({tag, "_pending"}, exp_q.size(), 0);
    chk({tag, "_tvalid_idle"}, 32'(tvalid), 0);
    chk_stats(tag);
  endtask

  initial begin
    int b0;
    rst_n = 1'b0; ce = 1'b0; hs = 1'b0; vs = 1'b0; rgb = '0; tready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tvalid", 32'(tvalid), 0);
    chk("rst_tdata", 32'(tdata), 0);
    chk("rst_tuser", 32'(tuser), 0);
    chk("rst_tlast", 32'(tlast), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk_stats("rst");
    rst_n = 1'b1;

    // Pixels before any vsync are ignored.
    ready_mode = 0; ce_gap = 1; b0 = beats;
    for (int i = 0; i < 6; i++) ce_cycle(1'(i % 3 != 2), 1'b0, 24'($urandom));
    repeat (4) clk_cycle(1'b0, 1'b0, 1'b0, 24'd0);
    chk("presync_beats", beats - b0, 0);
    chk("presync_tvalid", 32'(tvalid), 0);

    b0 = beats;
    send_frame(4, 3, 0, -1, 1);
    drain("ramp");
    chk("ramp_beats", beats - b0, 12);

    ready_mode = 1; b0 = beats;
    send_frame(4, 3, 0, -1, 1);
    ready_mode = 1;
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) clk_cycle(1'b0, 1'b0, 1'b0, 24'd0);
    drain("stall");
    chk("stall_beats", beats - b0, 12);
    chk("stall_ovf", 32'(ovf), 0);

    ce_gap = 0; ready_mode = 0;
    send_frame(6, 2, 0, -1, 0);
    drain("fullrate");

    for (int f = 0; f < 6; f++) begin
      ce_gap = $urandom_range(1, 2);
      ready_mode = 2;
      send_frame($urandom_range(1, 6), $urandom_range(1, 4), 1'($urandom), -1, 0);
    end
    ce_gap = 1;
    drain("random");
    chk("random_ovf", 32'(ovf), 0);

    // 32-pixel lines into a 16-entry FIFO with no consumer.
    ready_mode = 3;
    send_frame(32, 2, 0, 16, 0);
    chk("ovf_set", 32'(ovf), 1);
    chk("ovf_tvalid", 32'(tvalid), 1);
    ready_mode = 0;
    send_frame(5, 3, 0, -1, 0);
    drain("after_ovf");
    chk("ovf_sticky", 32'(ovf), 1);

    // Reset in the middle of a line with beats sitting in the FIFO.
    ready_mode = 3;
    ce_cycle(1'b0, 1'b1, 24'd0);
    repeat (2) ce_cycle(1'b0, 1'b0, 24'd0);
    for (int i = 0; i < 3; i++) ce_cycle(1'b1, 1'b0, 24'($urandom));
    @(posedge clk);
    #2;
    chk("prereset_tvalid", 32'(tvalid), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_tvalid", 32'(tvalid), 0);
    chk("midrst_tdata", 32'(tdata), 0);
    chk("midrst_ovf", 32'(ovf), 0);
    exp_q.delete();
    prev_stall = 1'b0;
    pend_valid = 0;
    exp_fw = 0; exp_fh = 0; exp_fc = 0;
    @(negedge clk);
    rst_n = 1'b1;
    ready_mode = 0;
    for (int i = 0; i < 3; i++) ce_cycle(1'b1, 1'b0, 24'($urandom));
    ce_cycle(1'b0, 1'b0, 24'd0);
    chk("postrst_tvalid", 32'(tvalid), 0);
    send_frame(4, 3, 1, -1, 0);
    drain("postrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
